sipo_frame: RTL and testbench
=============================

// Module: sipo_frame
// PURPOSE
//  Parametrised serial-in/parallel-out deserialiser with bit-valid qualifier, word framing and
//  valid/ready output handshake. Collects WIDTH serial bits into a word, holds it in an output
//  register until consumed, flags overrun. Successor to the fixed 4-bit SIPO; sits between a
//  serial receive front-end and any word-oriented consumer.
// PARAMETERS
//  WIDTH      8   word width in bits; legal range 2..32
//  MSB_FIRST  1   1: first received bit lands in d_out[WIDTH-1]; 0: first bit lands in d_out[0]
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  d_in       in   1      serial data bit
//  d_valid    in   1      d_in sampled only when high; gaps allowed anywhere in a word
//  clr        in   1      abort current partial word (framing resync)
//  d_out      out  WIDTH  completed word (held register)
//  out_valid  out  1      d_out holds an unconsumed word
//  out_ready  in   1      consumer accepts word when out_valid && out_ready
//  busy       out  1      partial word in progress (bit count != 0)
//  overrun    out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  - Reset (rst=1 at edge): shift reg, bit count, d_out, out_valid, overrun all 0; busy=0. Overrides all.
//  - Bit count cnt, $clog2(WIDTH) bits, 0..WIDTH-1. d_valid=1 at edge -> shift d_in in, cnt+1.
//  - Shift: MSB_FIRST=1: sr <= {sr[WIDTH-2:0], d_in}; MSB_FIRST=0: sr <= {d_in, sr[WIDTH-1:1]}.
//  - Completion: d_valid=1 and cnt==WIDTH-1 -> word = shift result including current bit; cnt wraps
//    to 0 same edge. Latency: out_valid high in the cycle after the edge sampling the last bit.
//  - Output register slot ("free" = !out_valid || out_ready at this edge):
//      completion & free      -> d_out<=word, out_valid<=1 (back-to-back words w/o bubble)
//      completion & !free     -> word dropped, d_out unchanged, overrun<=1
//      no completion & accept -> out_valid<=0, d_out keeps last value
//  - overrun sticky; cleared only by rst.
//  - clr=1 at edge: cnt<=0, sr<=0, current d_in bit discarded; output register, out_valid, overrun
//    unaffected. clr has priority over d_valid (no completion on that edge).
//  - busy = (cnt != 0), combinational from register.
//  - out_ready with out_valid=0 ignored. d_out stable while out_valid && !out_ready.
//  - Reset mid-word: partial bits lost, no word emitted.
// STRUCTURE
//  - Package sipo_pkg: function cnt_width(w) (= $clog2(w), min 1), localparam limits WIDTH_MIN=2,
//    WIDTH_MAX=32; elaboration check rejects out-of-range WIDTH.
//  - Sub-module sipo_shift_core: shift register + bit counter + clr; outputs word, word_done, busy.
//  - Top sipo_frame: output register, valid/ready slot, overrun flag.
// TESTING
//  1 WIDTH=4 MSB_FIRST=1, d_valid=1, bits 1,1,0,1, out_ready=1 -> d_out=4'b1101, out_valid 1 cycle.
//  2 WIDTH=4 MSB_FIRST=0, bits 1,1,0,1 -> d_out=4'b1011; with d_valid gaps of 2 cycles same result.
//  3 WIDTH=8, out_ready=0, send 0xA5 then 0x3C -> d_out stays 8'hA5, overrun=1; then out_ready=1
//    -> out_valid drops next edge, overrun remains 1 until rst.
//  4 WIDTH=8, continuous words 0x01,0x02 with out_ready=1 -> each word valid exactly 1 cycle, no loss.
//  5 WIDTH=4, send 1,1 then clr=1, then 0,0,1,1 -> d_out=4'b0011; busy 1 after first bit, 0 after clr.
//  6 Rst after 3 of 4 bits, then 1,0,1,0 -> d_out=4'b1010; all outputs 0 during/after rst edge.

Source files
------------

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared limits and helpers for the sipo_frame deserialiser
//   WIDTH_MIN / WIDTH_MAX : legal word-width range
//   cnt_width(w)          : bit-counter width for a w-bit word ($clog2(w), minimum 1)
package sipo_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - shift register and bit counter with framing clear
//   clk, rst   : clock, synchronous active-high reset
//   d_in       : serial data bit, sampled when d_valid is high
//   d_valid    : bit qualifier
//   clr        : abort partial word; wins over d_valid
//   word       : shift result including the current bit (meaningful when word_done)
//   word_done  : this edge completes a word
//   busy       : partial word in progress (bit count != 0)
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST != 0) begin
      sr_next = {sr[WIDTH-2:0], d_in};
    end else begin
      sr_next = {d_in, sr[WIDTH-1:1]};
    end
  end

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  // The completed word is taken from the shift input side so the final bit
  // is included on the same edge that wraps the counter.
  assign word      = sr_next;
  assign word_done = d_valid && !clr && last_bit;
  assign busy      = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (d_valid) begin
      sr  <= sr_next;
      cnt <= last_bit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_frame.sv
// rtl/sipo_frame.sv - serial-in/parallel-out deserialiser with valid/ready output slot
//   clk, rst   : clock, synchronous active-high reset
//   d_in       : serial data bit
//   d_valid    : d_in sampled only when high
//   clr        : abort current partial word
//   d_out      : completed word, held until consumed
//   out_valid  : d_out holds an unconsumed word
//   out_ready  : consumer accepts when out_valid && out_ready
//   busy       : partial word in progress
//   overrun    : sticky, a completed word was dropped
module sipo_frame
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] d_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("sipo_frame: WIDTH out of range 2..32");
    end
  endgenerate

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             slot_free;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .d_valid   (d_valid),
    .clr       (clr),
    .word      (word),
    .word_done (word_done),
    .busy      (busy)
  );

  // A slot being drained this edge can take a new word on the same edge,
  // so consecutive words need no bubble.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (word_done) begin
      if (slot_free) begin
        d_out     <= word;
        out_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame.sv
// tb/tb_sipo_frame.sv - directed-vector bench for sipo_frame
//   dut a: WIDTH=4 MSB_FIRST=1, dut b: WIDTH=4 MSB_FIRST=0, dut c: WIDTH=8 MSB_FIRST=1
//   all three share the same stimulus inputs
module tb_sipo_frame;

  logic       clk;
  logic       rst;
  logic       d_in;
  logic       d_valid;
  logic       clr;
  logic       out_ready;

  logic [3:0] a_d_out;
  logic       a_out_valid, a_busy, a_overrun;
  logic [3:0] b_d_out;
  logic       b_out_valid, b_busy, b_overrun;
  logic [7:0] c_d_out;
  logic       c_out_valid, c_busy, c_overrun;

  int n_vec  = 0;
  int n_miss = 0;
  int vcount;

  sipo_frame #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .clr(clr),
    .d_out(a_d_out), .out_valid(a_out_valid), .out_ready(out_ready),
    .busy(a_busy), .overrun(a_overrun)
  );

  sipo_frame #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .clr(clr),
    .d_out(b_d_out), .out_valid(b_out_valid), .out_ready(out_ready),
    .busy(b_busy), .overrun(b_overrun)
  );

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .clr(clr),
    .d_out(c_d_out), .out_valid(c_out_valid), .out_ready(out_ready),
    .busy(c_busy), .overrun(c_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    d_valid = 1'b1;
    d_in    = b;
    step();
    d_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    d_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
    end
  endtask

  initial begin
    rst = 1'b1; d_in = 1'b0; d_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    step();
    check_vec("rst_a_dout",  {28'd0, a_d_out},     32'h0);
    check_vec("rst_a_valid", {31'd0, a_out_valid}, 32'h0);
    check_vec("rst_a_busy",  {31'd0, a_busy},      32'h0);
    check_vec("rst_c_ovr",   {31'd0, c_overrun},   32'h0);
    rst = 1'b0;

    // Test 1/2: 1,1,0,1 continuous, both bit orders
    out_ready = 1'b1;
    send_bit(1'b1);
    check_vec("t1_busy_first", {31'd0, a_busy}, 32'h1);
    send_bit(1'b1);
    send_bit(1'b0);
    check_vec("t1_valid_early", {31'd0, a_out_valid}, 32'h0);
    send_bit(1'b1);
    check_vec("t1_a_dout",  {28'd0, a_d_out},     32'hD);
    check_vec("t1_a_valid", {31'd0, a_out_valid}, 32'h1);
    check_vec("t1_a_busy",  {31'd0, a_busy},      32'h0);
    check_vec("t2_b_dout",  {28'd0, b_d_out},     32'hB);
    idle(1);
    check_vec("t1_a_valid_drop", {31'd0, a_out_valid}, 32'h0);
    check_vec("t1_a_dout_keep",  {28'd0, a_d_out},     32'hD);

    // Test 2: same bits with 2-cycle gaps
    do_reset();
    send_bit(1'b1); idle(2);
    send_bit(1'b1); idle(2);
    send_bit(1'b0); idle(2);
    check_vec("t2_gap_busy", {31'd0, b_busy}, 32'h1);
    send_bit(1'b1);
    check_vec("t2_gap_b_dout",  {28'd0, b_d_out},     32'hB);
    check_vec("t2_gap_b_valid", {31'd0, b_out_valid}, 32'h1);
    check_vec("t2_gap_a_dout",  {28'd0, a_d_out},     32'hD);

    // Test 3: overrun with out_ready low
    do_reset();
    out_ready = 1'b0;
    send_byte(8'hA5);
    check_vec("t3_c_first", {24'd0, c_d_out}, 32'hA5);
    check_vec("t3_c_ovr0",  {31'd0, c_overrun}, 32'h0);
    send_byte(8'h3C);
    check_vec("t3_c_hold",  {24'd0, c_d_out},     32'hA5);
    check_vec("t3_c_valid", {31'd0, c_out_valid}, 32'h1);
    check_vec("t3_c_ovr",   {31'd0, c_overrun},   32'h1);
    check_vec("t3_a_first", {28'd0, a_d_out},     32'hA);
    check_vec("t3_a_ovr",   {31'd0, a_overrun},   32'h1);
    out_ready = 1'b1;
    idle(1);
    check_vec("t3_c_drop",  {31'd0, c_out_valid}, 32'h0);
    check_vec("t3_c_ovr_sticky", {31'd0, c_overrun}, 32'h1);
    idle(2);
    check_vec("t3_c_ovr_sticky2", {31'd0, c_overrun}, 32'h1);
    do_reset();
    check_vec("t3_c_ovr_rst", {31'd0, c_overrun}, 32'h0);

    // Test 4: back-to-back bytes with out_ready high
    out_ready = 1'b1;
    vcount = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(i == 0);
      vcount += int'(c_out_valid);
    end
    check_vec("t4_w1_dout", {24'd0, c_d_out}, 32'h01);
    for (int i = 7; i >= 0; i--) begin
      send_bit(i == 1);
      vcount += int'(c_out_valid);
      if (i == 7) check_vec("t4_w1_one_cycle", {31'd0, c_out_valid}, 32'h0);
    end
    check_vec("t4_w2_dout",  {24'd0, c_d_out},     32'h02);
    check_vec("t4_w2_valid", {31'd0, c_out_valid}, 32'h1);
    idle(1);
    vcount += int'(c_out_valid);
    check_vec("t4_vcount", 32'(vcount), 32'd2);
    check_vec("t4_no_ovr", {31'd0, c_overrun}, 32'h0);

    // Test 5: clr aborts partial word; clr wins over d_valid
    do_reset();
    send_bit(1'b1);
    check_vec("t5_busy1", {31'd0, a_busy}, 32'h1);
    send_bit(1'b1);
    clr = 1'b1;
    send_bit(1'b1);
    clr = 1'b0;
    check_vec("t5_busy_clr",  {31'd0, a_busy},      32'h0);
    check_vec("t5_valid_clr", {31'd0, a_out_valid}, 32'h0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check_vec("t5_a_dout",  {28'd0, a_d_out},     32'h3);
    check_vec("t5_a_valid", {31'd0, a_out_valid}, 32'h1);

    // Test 6: reset mid-word
    idle(1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    d_valid = 1'b1; d_in = 1'b1;
    step();
    d_valid = 1'b0;
    rst = 1'b0;
    check_vec("t6_rst_dout",  {28'd0, a_d_out},     32'h0);
    check_vec("t6_rst_valid", {31'd0, a_out_valid}, 32'h0);
    check_vec("t6_rst_busy",  {31'd0, a_busy},      32'h0);
    check_vec("t6_rst_ovr",   {31'd0, a_overrun},   32'h0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check_vec("t6_a_dout", {28'd0, a_d_out}, 32'hA);
    check_vec("t6_b_dout", {28'd0, b_d_out}, 32'h5);

    // Test 7: new word lands on the edge that consumes the held word
    do_reset();
    out_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check_vec("t7_hold_valid", {31'd0, a_out_valid}, 32'h1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check_vec("t7_hold_dout", {28'd0, a_d_out}, 32'hD);
    out_ready = 1'b1;
    send_bit(1'b0);
    check_vec("t7_b2b_dout",  {28'd0, a_d_out},     32'h6);
    check_vec("t7_b2b_valid", {31'd0, a_out_valid}, 32'h1);
    check_vec("t7_b2b_ovr",   {31'd0, a_overrun},   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
